// File: rtl/tt_um_uio_regport.sv
// Host-strobed register port: 7 RW registers plus a constant ID register on the bidirectional bus.
// Optional write-parity checking is enabled by defining REGPORT_PARITY_EN.
module tt_um_uio_regport (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] ID_VALUE = 8'hA5;

    typedef enum logic [2:0] {IDLE, WR_ACK, RD_DRV, RD_ACK, TURN} state_t;

    state_t            state;
    logic              stb_p0, stb_p1, stb_p2;
    logic [DATA_W-1:0] regs [0:6];
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        rd_addr;
    logic [2:0]        last_addr;
    logic [2:0]        txn_cnt;
    logic              drive;
    logic              ack;
    logic              err;
    logic              rise;
    logic              rw;
    logic [2:0]        addr;
    logic              par_bad;

    assign rw   = ui_in[1];
    assign addr = ui_in[4:2];
    assign rise = stb_p1 & ~stb_p2;

`ifdef REGPORT_PARITY_EN
    // Even parity across PAR and the 8 data bits.
    assign par_bad = ui_in[5] != ^uio_in;
    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:6]};
`else
    assign par_bad = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:5]};
`endif

    function automatic logic [DATA_W-1:0] read_mux(input logic [2:0] a);
        if (a == 3'd7)
            return ID_VALUE;
        return regs[a];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_p0    <= 1'b0;
            stb_p1    <= 1'b0;
            stb_p2    <= 1'b0;
            state     <= IDLE;
            drive     <= 1'b0;
            ack       <= 1'b0;
            rd_data   <= '0;
            rd_addr   <= '0;
            last_addr <= '0;
            txn_cnt   <= '0;
            err       <= 1'b0;
            for (int i = 0; i < 7; i++)
                regs[i] <= '0;
        end else begin
            // Strobe synchronizer and edge-detect stage
            stb_p0 <= ui_in[0];
            stb_p1 <= stb_p0;
            stb_p2 <= stb_p1;

            if (!ena) begin
                state   <= IDLE;
                drive   <= 1'b0;
                ack     <= 1'b0;
                rd_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            if (rw) begin
                                rd_addr <= addr;
                                rd_data <= read_mux(addr);
                                drive   <= 1'b1;
                                state   <= RD_DRV;
                            end else begin
                                // A parity-failed write is still acked and counted.
                                if (addr != 3'd7 && !par_bad)
                                    regs[addr] <= uio_in;
                                err       <= err | par_bad;
                                ack       <= 1'b1;
                                last_addr <= addr;
                                txn_cnt   <= txn_cnt + 3'd1;
                                state     <= WR_ACK;
                            end
                        end
                    end
                    RD_DRV: begin
                        ack       <= 1'b1;
                        last_addr <= rd_addr;
                        txn_cnt   <= txn_cnt + 3'd1;
                        state     <= RD_ACK;
                    end
                    RD_ACK: begin
                        if (!stb_p1) begin
                            ack     <= 1'b0;
                            drive   <= 1'b0;
                            rd_data <= '0;
                            state   <= TURN;
                        end
                    end
                    TURN: begin
                        state <= IDLE;
                    end
                    WR_ACK: begin
                        if (!stb_p1) begin
                            ack   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        drive   <= 1'b0;
                        ack     <= 1'b0;
                        rd_data <= '0;
                    end
                endcase
            end
        end
    end

    assign uo_out  = {txn_cnt, last_addr, err, ack};
    assign uio_oe  = {8{drive}};
    assign uio_out = rd_data;

endmodule

// File: tb/tb_tt_um_uio_regport.sv
// Self-checking bench for tt_um_uio_regport: randomized host transactions against a register-file model.
module tb_tt_um_uio_regport;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [0:7];
    int         m_cnt;
    int         m_last;
    bit         m_err;

    always #5 clk = ~clk;

    tt_um_uio_regport dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_mem[i] = 8'h00;
        m_mem[7] = 8'hA5;
        m_cnt  = 0;
        m_last = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d, input bit par);
        bit good;
        good = 1'b1;
`ifdef REGPORT_PARITY_EN
        good = (par == ^d);
        if (!good) m_err = 1'b1;
`endif
        if (good && a != 3'd7) m_mem[a] = d;
        m_cnt  = (m_cnt + 1) % 8;
        m_last = a;
    endtask

    function automatic logic [7:0] m_status(input bit a);
        return {3'(m_cnt), 3'(m_last), m_err, a};
    endfunction

    // Full host handshake with inline checks of the bus and status at each phase.
    task automatic do_txn(input bit rw, input logic [2:0] a, input logic [7:0] d, input bit par, input string tag);
        logic [7:0] exp_rd;
        logic [7:0] prev_oe;
        logic [7:0] prev_out;
        bit         got;
        prev_oe  = 8'h00;
        prev_out = 8'h00;
        got      = 1'b0;
        ui_in  = {2'b00, par, a, rw, 1'b0};
        uio_in = d;
        tick(2);
        ui_in[0] = 1'b1;
        exp_rd = m_mem[a];
        for (int n = 0; n < 12; n++) begin
            tick();
            if (uo_out[0]) begin
                got = 1'b1;
                break;
            end
            prev_oe  = uio_oe;
            prev_out = uio_out;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s ack_timeout: ack=%b required 1", tag, uo_out[0]);
            ui_in[0] = 1'b0;
            tick(4);
            return;
        end
        if (rw) begin
            m_cnt  = (m_cnt + 1) % 8;
            m_last = a;
        end else begin
            model_write(a, d, par);
        end
        checks++;
        if (uo_out !== m_status(1'b1)) begin
            errors++;
            $display("FAIL %s status_at_ack: got %h required %h", tag, uo_out, m_status(1'b1));
        end
        if (rw) begin
            checks++;
            if (prev_oe !== 8'hFF || prev_out !== exp_rd) begin
                errors++;
                $display("FAIL %s read_before_ack: oe=%h data=%h required oe=ff data=%h", tag, prev_oe, prev_out, exp_rd);
            end
            checks++;
            if (uio_oe !== 8'hFF || uio_out !== exp_rd) begin
                errors++;
                $display("FAIL %s read_at_ack: oe=%h data=%h required oe=ff data=%h", tag, uio_oe, uio_out, exp_rd);
            end
        end else begin
            checks++;
            if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
                errors++;
                $display("FAIL %s write_bus: oe=%h data=%h required 00 00", tag, uio_oe, uio_out);
            end
        end
        ui_in[0] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (!uo_out[0]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || uio_oe !== 8'h00 || uio_out !== 8'h00 || uo_out !== m_status(1'b0)) begin
            errors++;
            $display("FAIL %s release: status=%h oe=%h data=%h required status=%h oe=00 data=00",
                     tag, uo_out, uio_oe, uio_out, m_status(1'b0));
        end
        tick();
        checks++;
        if (uio_oe !== 8'h00 || uo_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: oe=%h ack=%b required 00 0", tag, uio_oe, uo_out[0]);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'h00;
        tick(3);
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: uo=%h uio_out=%h oe=%h required 00 00 00", uo_out, uio_out, uio_oe);
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_cycle: uo=%h uio_out=%h oe=%h required 00 00 00", uo_out, uio_out, uio_oe);
        end
    endtask

    task automatic test_write_read();
        do_txn(1'b0, 3'd2, 8'h3C, ^8'h3C, "wr2");
        do_txn(1'b1, 3'd2, 8'h00, 1'b0, "rd2");
        checks++;
        if (uo_out[4:2] !== 3'd2 || uo_out[7:5] !== 3'd2) begin
            errors++;
            $display("FAIL wr_rd_status: addr=%0d cnt=%0d required 2 2", uo_out[4:2], uo_out[7:5]);
        end
    endtask

    task automatic test_r7();
        do_txn(1'b0, 3'd7, 8'h11, ^8'h11, "wr7");
        do_txn(1'b1, 3'd7, 8'h00, 1'b0, "rd7");
    endtask

    task automatic test_back_to_back();
        logic [2:0] a;
        logic [7:0] d;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            do_txn(1'b0, a, d, ^d, "b2b");
            checks++;
            if (uo_out[7:5] !== 3'((i + 1) % 8)) begin
                errors++;
                $display("FAIL b2b_count: got %0d required %0d", uo_out[7:5], (i + 1) % 8);
            end
        end
        checks++;
        if (uo_out[7:5] !== 3'd1) begin
            errors++;
            $display("FAIL b2b_final_count: got %0d required 1", uo_out[7:5]);
        end
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [7:0] d;
        bit         rw;
        bit         par;
        for (int i = 0; i < 40; i++) begin
            rw  = 1'($urandom_range(0, 1));
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            do_txn(rw, a, d, par, rw ? "rand_rd" : "rand_wr");
        end
    endtask

    task automatic test_reset_mid_read();
        bit got;
        do_txn(1'b0, 3'd4, 8'h5A, ^8'h5A, "wr4");
        ui_in = {2'b00, 1'b0, 3'd4, 1'b1, 1'b0};
        tick(2);
        ui_in[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (uo_out[0]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || uio_oe !== 8'hFF || uio_out !== 8'h5A) begin
            errors++;
            $display("FAIL rst_mid_rd_ack: ack=%b oe=%h data=%h required 1 ff 5a", uo_out[0], uio_oe, uio_out);
        end
        rst_n = 1'b0;
        ui_in = 8'h00;
        tick();
        checks++;
        if (uio_oe !== 8'h00 || uo_out[0] !== 1'b0 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_rd_release: oe=%h ack=%b data=%h required 00 0 00", uio_oe, uo_out[0], uio_out);
        end
        rst_n = 1'b1;
        model_reset();
        tick(2);
        do_txn(1'b1, 3'd4, 8'h00, 1'b0, "rd4_after_rst");
    endtask

    task automatic test_ena_drop();
        bit got;
        bit any_ack;
        ui_in = {2'b00, 1'b0, 3'd5, 1'b1, 1'b0};
        tick(2);
        ui_in[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (uo_out[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            m_cnt  = (m_cnt + 1) % 8;
            m_last = 5;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ena_drop_ack: ack=%b required 1", uo_out[0]);
        end
        ena = 1'b0;
        tick();
        checks++;
        if (uio_oe !== 8'h00 || uo_out[0] !== 1'b0 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL ena_drop_release: oe=%h ack=%b data=%h required 00 0 00", uio_oe, uo_out[0], uio_out);
        end
        ui_in[0] = 1'b0;
        tick(3);
        ui_in  = {2'b00, 1'b0, 3'd3, 1'b0, 1'b0};
        uio_in = ~m_mem[3];
        tick(2);
        ui_in[0] = 1'b1;
        any_ack = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (uo_out[0]) any_ack = 1'b1;
        end
        ui_in[0] = 1'b0;
        tick(3);
        checks++;
        if (any_ack || uo_out !== m_status(1'b0)) begin
            errors++;
            $display("FAIL ena_off_strobe: ack_seen=%b status=%h required 0 %h", any_ack, uo_out, m_status(1'b0));
        end
        ena = 1'b1;
        tick(2);
        do_txn(1'b1, 3'd3, 8'h00, 1'b0, "rd3_after_ena");
    endtask

    task automatic test_parity();
        do_txn(1'b0, 3'd1, 8'h03, 1'b1, "par_wr1");
        checks++;
        if (uo_out[1] !== m_err) begin
            errors++;
            $display("FAIL parity_err: got %b required %b", uo_out[1], m_err);
        end
        do_txn(1'b1, 3'd1, 8'h00, 1'b0, "par_rd1");
        do_txn(1'b0, 3'd5, 8'h81, ^8'h81, "par_wr5");
        checks++;
        if (uo_out[1] !== m_err) begin
            errors++;
            $display("FAIL parity_err_sticky: got %b required %b", uo_out[1], m_err);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        test_reset();
        test_write_read();
        test_r7();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_ena_drop();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
